nco_sweep_ctrl: RTL and testbench

NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

---
 rtl/nco_pkg.sv | 19 +
 rtl/nco_dwell_cnt.sv | 31 +++
 rtl/nco_sweep_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared definitions for the NCO frequency-sweep controller: default widths,
// full-scale tuning-word constant and the sweep state encoding.
package nco_pkg;

   localparam int FW_DEF = 28;
   localparam int DW_DEF = 16;

   // Tuning word that corresponds to the NCO sample rate (one full phase turn per clock).
   localparam int unsigned NCO_FULL_SCALE = 2**28;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_DWELL = 3'd2,
      ST_STEP  = 3'd3,
      ST_DONE  = 3'd4
   } nco_state_t;

endpackage

// File: rtl/nco_dwell_cnt.sv
// Dwell counter: loaded with the hold length minus one, counts down while
// enabled and flags expiry on the last cycle of the hold.
module nco_dwell_cnt
   import nco_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [DW-1:0] load_val,
   input  logic          en,
   output logic          expire
);

   logic [DW-1:0] cnt;

   // Remaining hold cycles for the current frequency point.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = en && (cnt == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// NCO frequency-sweep controller. Accepts a sweep descriptor, steps the
// tuning word from start towards stop (clamped at stop), holding each point
// for dwell+1 cycles, with optional looping and abort.
// Optional feature: define NCO_SWEEP_PHASE_CLR_EN to emit a phase_clr pulse
// alongside the freq_upd of every sweep start (including loop restarts);
// otherwise phase_clr is tied low.
module nco_sweep_ctrl
   import nco_pkg::*;
#(
   parameter int FW = FW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [FW-1:0] cfg_start,
   input  logic [FW-1:0] cfg_stop,
   input  logic [FW-1:0] cfg_step,
   input  logic [DW-1:0] cfg_dwell,
   input  logic          cfg_loop,
   input  logic          abort,
   output logic [FW-1:0] freq,
   output logic          freq_upd,
   output logic          phase_clr,
   output logic          busy,
   output logic          done
);

   nco_state_t    state;
   nco_state_t    state_nxt;

   logic [FW-1:0] start_r;
   logic [FW-1:0] stop_r;
   logic [FW-1:0] step_r;
   logic [DW-1:0] dwell_r;
   logic          loop_r;
   logic          degen_r;

   logic [FW-1:0] freq_nxt;
   logic          upd_nxt;
   logic          cnt_load;
   logic          accept;
   logic          expire;
`ifdef NCO_SWEEP_PHASE_CLR_EN
   logic          load_pt;
`endif

   // Next point: the sum is formed one bit wider so a wrap past full scale
   // is seen as overshoot and clamped to the stop word like any other.
   function automatic logic [FW-1:0] clamp_next(input logic [FW-1:0] cur,
                                                input logic [FW-1:0] stp,
                                                input logic [FW-1:0] lim);
      logic [FW:0] sum;
      sum = {1'b0, cur} + {1'b0, stp};
      if (sum[FW] || (sum[FW-1:0] >= lim)) begin
         clamp_next = lim;
      end else begin
         clamp_next = sum[FW-1:0];
      end
   endfunction

   // Descriptor is only taken while idle; this is a pure function of state.
   assign cfg_ready = (state == ST_IDLE);

   nco_dwell_cnt #(
      .DW(DW)
   ) u_dwell (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (dwell_r),
      .en       (state == ST_DWELL),
      .expire   (expire)
   );

   // Sweep sequencing: next state, next tuning word and update strobes.
   always_comb begin
      state_nxt = state;
      freq_nxt  = freq;
      upd_nxt   = 1'b0;
      cnt_load  = 1'b0;
      accept    = 1'b0;
`ifdef NCO_SWEEP_PHASE_CLR_EN
      load_pt   = 1'b0;
`endif
      if (abort) begin
         // Abort wins over everything but reset, including a pending handshake.
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cfg_valid) begin
                  accept    = 1'b1;
                  state_nxt = ST_LOAD;
               end
            end
            ST_LOAD: begin
               freq_nxt  = start_r;
               upd_nxt   = 1'b1;
               cnt_load  = 1'b1;
`ifdef NCO_SWEEP_PHASE_CLR_EN
               load_pt   = 1'b1;
`endif
               state_nxt = ST_DWELL;
            end
            ST_DWELL: begin
               if (expire) begin
                  state_nxt = ST_STEP;
               end
            end
            ST_STEP: begin
               // Degenerate descriptors never advance past the start point.
               if (degen_r || (freq == stop_r)) begin
                  state_nxt = loop_r ? ST_LOAD : ST_DONE;
               end else begin
                  freq_nxt  = clamp_next(freq, step_r, stop_r);
                  upd_nxt   = 1'b1;
                  cnt_load  = 1'b1;
                  state_nxt = ST_DWELL;
               end
            end
            ST_DONE: begin
               state_nxt = ST_IDLE;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Descriptor latch; reset discards any sweep in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         start_r <= '0;
         stop_r  <= '0;
         step_r  <= '0;
         dwell_r <= '0;
         loop_r  <= 1'b0;
         degen_r <= 1'b0;
      end else if (accept) begin
         start_r <= cfg_start;
         stop_r  <= cfg_stop;
         step_r  <= cfg_step;
         dwell_r <= cfg_dwell;
         loop_r  <= cfg_loop;
         degen_r <= (cfg_step == '0) || (cfg_start >= cfg_stop);
      end
   end

   // Registered outputs, aligned with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         freq     <= '0;
         freq_upd <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         freq     <= freq_nxt;
         freq_upd <= upd_nxt;
         busy     <= (state_nxt != ST_IDLE);
         done     <= (state_nxt == ST_DONE);
      end
   end

`ifdef NCO_SWEEP_PHASE_CLR_EN
   // Accumulator clear accompanies the start-point update of every sweep pass.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_clr <= 1'b0;
      end else begin
         phase_clr <= load_pt;
      end
   end
`else
   assign phase_clr = 1'b0;
`endif

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl. Stimulus pushes expected freq_upd/done
// events (value and cycle) computed from the sweep rules; a monitor pops and
// compares whenever the DUT presents one.
module tb_nco_sweep_ctrl;
   import nco_pkg::*;

   localparam int FW = 28;
   localparam int DW = 16;
`ifdef NCO_SWEEP_PHASE_CLR_EN
   localparam bit PC_EN = 1'b1;
`else
   localparam bit PC_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [FW-1:0] cfg_start;
   logic [FW-1:0] cfg_stop;
   logic [FW-1:0] cfg_step;
   logic [DW-1:0] cfg_dwell;
   logic          cfg_loop;
   logic          abort;
   logic [FW-1:0] freq;
   logic          freq_upd;
   logic          phase_clr;
   logic          busy;
   logic          done;

   nco_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
      .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop), .abort(abort),
      .freq(freq), .freq_upd(freq_upd), .phase_clr(phase_clr),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_done;
      longint      val;
      bit          pc;
      int unsigned t;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;
   int  errors = 0;
   int  checks = 0;

   function automatic void check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Monitor: every freq_upd or done must match the oldest expected event.
   always @(negedge clk) begin
      if (freq_upd || done) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: upd=%0b done=%0b freq=%0d cycle=%0d, nothing expected",
                     freq_upd, done, freq, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if ((done !== mon_e.is_done) || (freq_upd !== !mon_e.is_done) || (cyc != mon_e.t) ||
                (!mon_e.is_done && ((longint'(freq) != mon_e.val) || (phase_clr !== mon_e.pc)))) begin
               errors++;
               $display("FAIL event: got upd=%0b done=%0b freq=%0d pc=%0b cycle=%0d, expected done=%0b freq=%0d pc=%0b cycle=%0d",
                        freq_upd, done, freq, phase_clr, cyc, mon_e.is_done, mon_e.val, mon_e.pc, mon_e.t);
            end
         end
      end
      if (phase_clr && !freq_upd) begin
         checks++;
         errors++;
         $display("FAIL stray_phase_clr: got phase_clr=1 without freq_upd, expected 0 (cycle %0d)", cyc);
      end
   end

   // Reference: list of frequency points a descriptor visits.
   task automatic gen_points(input longint st, input longint sp, input longint stp, output longint pts[$]);
      longint p;
      pts.delete();
      pts.push_back(st);
      if (stp != 0 && st < sp) begin
         p = st;
         while (p < sp) begin
            p = p + stp;
            if (p > sp) p = sp;
            pts.push_back(p);
         end
      end
   endtask

   task automatic push_upd(input longint v, input bit first, input int unsigned t);
      ev_t e;
      e.is_done = 1'b0; e.val = v; e.pc = first && PC_EN; e.t = t;
      exp_q.push_back(e);
   endtask

   task automatic push_done(input int unsigned t);
      ev_t e;
      e.is_done = 1'b1; e.val = 0; e.pc = 1'b0; e.t = t;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int unsigned t);
      while (cyc < t) @(negedge clk);
   endtask

   // Present a descriptor; h is the cycle in which LOAD is visible.
   task automatic issue(input longint st, input longint sp, input longint stp, input int unsigned dw,
                        input bit lp, input bit keep, output int unsigned h);
      int n;
      n = 0;
      @(negedge clk);
      while (!cfg_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cfg_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got cfg_ready=0 expected 1 within 200 cycles");
      end
      cfg_valid = 1'b1;
      cfg_start = st[FW-1:0];
      cfg_stop  = sp[FW-1:0];
      cfg_step  = stp[FW-1:0];
      cfg_dwell = dw[DW-1:0];
      cfg_loop  = lp;
      h = cyc + 1;
      @(negedge clk);
      if (!keep) cfg_valid = 1'b0;
   endtask

   // One-shot sweep: each point is dwell+1 cycles in DWELL plus one STEP cycle.
   task automatic run_oneshot(input longint st, input longint sp, input longint stp, input int unsigned dw);
      int unsigned h, n, t_end;
      longint pts[$];
      issue(st, sp, stp, dw, 1'b0, 1'b0, h);
      gen_points(st, sp, stp, pts);
      n = pts.size();
      for (int unsigned i = 0; i < n; i++) push_upd(pts[i], i == 0, h + 1 + i * (dw + 2));
      t_end = h + 1 + n * (dw + 2);
      push_done(t_end);
      wait_cyc(t_end);
      check("busy_in_done", longint'(busy), 1);
      wait_cyc(t_end + 1);
      check("busy_after_done", longint'(busy), 0);
      check("freq_retained", longint'(freq), pts[n-1]);
      check("ready_after_done", longint'(cfg_ready), 1);
      check("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no end of test, expected finish within time limit");
      $fatal(1);
   end

   initial begin
      int unsigned h, t_end, drop;
      longint pts[$];
      longint st, sp, stp, rng;
      int unsigned dw, mode;

      rst = 1'b1; cfg_valid = 1'b0; cfg_start = '0; cfg_stop = '0; cfg_step = '0;
      cfg_dwell = '0; cfg_loop = 1'b0; abort = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_freq", longint'(freq), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);
      check("rst_upd", longint'(freq_upd), 0);
      check("rst_pclr", longint'(phase_clr), 0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", longint'(cfg_ready), 1);

      // Directed sweeps: basic, clamp with carry, both degenerate forms.
      run_oneshot(268435, 1073741, 268435, 3);
      run_oneshot(NCO_FULL_SCALE - 10, NCO_FULL_SCALE - 1, 100, 2);
      run_oneshot(1000, 5000, 0, 0);
      run_oneshot(5000, 1000, 7, 1);

      // Loop mode: restart at start after stop, then abort in the second pass.
      issue(100, 300, 100, 1, 1'b1, 1'b0, h);
      push_upd(100, 1'b1, h + 1);
      push_upd(200, 1'b0, h + 4);
      push_upd(300, 1'b0, h + 7);
      push_upd(100, 1'b1, h + 11);
      push_upd(200, 1'b0, h + 14);
      wait_cyc(h + 14);
      abort = 1'b1;
      wait_cyc(h + 15);
      abort = 1'b0;
      check("loop_abort_busy", longint'(busy), 0);
      check("loop_abort_freq", longint'(freq), 200);
      wait_cyc(h + 30);
      check("loop_queue", exp_q.size(), 0);

      // Abort during the second dwell of a one-shot sweep.
      issue(1000, 1300, 100, 2, 1'b0, 1'b0, h);
      push_upd(1000, 1'b1, h + 1);
      push_upd(1100, 1'b0, h + 5);
      wait_cyc(h + 6);
      abort = 1'b1;
      wait_cyc(h + 7);
      abort = 1'b0;
      check("abort_busy", longint'(busy), 0);
      check("abort_freq", longint'(freq), 1100);
      check("abort_ready", longint'(cfg_ready), 1);
      wait_cyc(h + 20);
      check("abort_queue", exp_q.size(), 0);

      // Abort in the same cycle as a handshake: not accepted.
      @(negedge clk);
      abort = 1'b1; cfg_valid = 1'b1; cfg_start = 28'd10; cfg_stop = 28'd20; cfg_step = 28'd1;
      @(negedge clk);
      abort = 1'b0; cfg_valid = 1'b0;
      check("abort_vs_hs_busy", longint'(busy), 0);
      repeat (3) @(negedge clk);

      // Reset mid-dwell, together with abort and a handshake attempt.
      issue(2000, 9000, 1000, 5, 1'b0, 1'b0, h);
      push_upd(2000, 1'b1, h + 1);
      wait_cyc(h + 3);
      rst = 1'b1; abort = 1'b1; cfg_valid = 1'b1;
      wait_cyc(h + 4);
      check("midrst_freq", longint'(freq), 0);
      check("midrst_busy", longint'(busy), 0);
      check("midrst_upd", longint'(freq_upd), 0);
      check("midrst_done", longint'(done), 0);
      check("midrst_pclr", longint'(phase_clr), 0);
      rst = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
      wait_cyc(h + 5);
      check("midrst_ready", longint'(cfg_ready), 1);
      check("midrst_busy_after", longint'(busy), 0);
      check("midrst_queue", exp_q.size(), 0);

      // cfg_valid held high (with changing fields) while busy: one accept only.
      issue(3000, 3500, 200, 1, 1'b0, 1'b1, h);
      gen_points(3000, 3500, 200, pts);
      for (int unsigned i = 0; i < pts.size(); i++) push_upd(pts[i], i == 0, h + 1 + i * 3);
      t_end = h + 1 + pts.size() * 3;
      push_done(t_end);
      cfg_start = 28'd777; cfg_stop = 28'd999999; cfg_step = 28'd1;
      drop = 0;
      while (cyc < t_end) begin
         if (!busy) drop++;
         @(negedge clk);
      end
      cfg_valid = 1'b0;
      check("held_valid_busy_gaps", drop, 0);
      wait_cyc(t_end + 4);
      check("held_valid_idle", longint'(busy), 0);
      check("held_valid_queue", exp_q.size(), 0);

      // Randomized descriptors.
      for (int k = 0; k < 10; k++) begin
         mode = $urandom_range(0, 3);
         dw   = $urandom_range(0, 3);
         case (mode)
            0: begin
               rng = $urandom_range(1, 1 << 20);
               st  = $urandom_range(0, NCO_FULL_SCALE - 1 - int'(rng));
               sp  = st + rng;
               stp = rng / $urandom_range(1, 12);
               if (stp == 0) stp = 1;
            end
            1: begin
               sp  = NCO_FULL_SCALE - 1 - $urandom_range(0, 50);
               st  = sp - $urandom_range(1, 1000);
               stp = $urandom_range(200, 1 << 27);
            end
            2: begin
               st  = $urandom_range(0, NCO_FULL_SCALE - 1);
               sp  = $urandom_range(0, NCO_FULL_SCALE - 1);
               stp = 0;
            end
            default: begin
               sp  = $urandom_range(0, 1 << 27);
               st  = sp + $urandom_range(0, 1000);
               stp = $urandom_range(1, 1 << 20);
            end
         endcase
         run_oneshot(st, sp, stp, dw);
      end

      repeat (5) @(negedge clk);
      check("final_queue", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
